// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
//   ps2_state_t   : frame deframer states
//   PS2_EXT/BRK   : extended and break prefix bytes
//   parity_ok     : odd-parity check over a data byte plus its parity bit
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Odd parity: data ones plus parity bit must be odd.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return (^data) ^ par;
  endfunction

endpackage

// File: rtl/ps2_key_receiver_sync_edge.sv
// Brings the asynchronous PS/2 clock and data lines into the i_clk domain and
// flags falling edges of the synchronized PS/2 clock.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_ps2_clk      : raw PS/2 clock line
//   i_ps2_dat      : raw PS/2 data line
//   sync_dat       : synchronized data, aligned with the synchronized clock
//   fall           : combinational one-cycle pulse, synchronized clock went 1->0
module ps2_key_receiver_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic sync_dat,
  output logic fall
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic dat_meta_q, dat_meta_d;
  logic dat_sync_q, dat_sync_d;

  // Two-stage synchronizers plus one delayed copy of the clock for edge detect.
  always_comb begin
    clk_meta_d = i_ps2_clk;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = i_ps2_dat;
    dat_sync_d = dat_meta_q;
  end

  // Reset to 1: the PS/2 bus idles high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  assign sync_dat = dat_sync_q;
  assign fall     = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard front end: deframes 11-bit device-to-host frames, strips the
// E0/F0 prefixes and reports key events plus the currently held key.
//   i_clk, i_rst_n        : system clock, async active-low reset
//   i_ps2_clk, i_ps2_dat  : raw asynchronous PS/2 lines
//   o_valid               : one-cycle key event strobe
//   o_code/o_ext/o_release: last event (held until the next event)
//   o_key                 : currently held key code, 8'h00 when none
//   o_err                 : one-cycle strobe on parity/stop/timeout error
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic       o_valid,
  output logic [7:0] o_code,
  output logic       o_ext,
  output logic       o_release,
  output logic [7:0] o_key,
  output logic       o_err
);

  localparam int unsigned BIT_CNT_W = 3;

  logic sync_dat;
  logic fall;

  ps2_key_receiver_sync_edge u_sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .sync_dat  (sync_dat),
    .fall      (fall)
  );

  ps2_state_t           state_q, state_d;
  logic [7:0]           shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ext_q, ext_d;
  logic                 brk_q, brk_d;
  logic                 valid_q, valid_d;
  logic [7:0]           code_q, code_d;
  logic                 oext_q, oext_d;
  logic                 orel_q, orel_d;
  logic [7:0]           key_q, key_d;
  logic                 err_q, err_d;

  // Deframer, prefix tracking, event generation and inactivity timeout.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    valid_d   = 1'b0;
    code_d    = code_q;
    oext_d    = oext_q;
    orel_d    = orel_q;
    key_d     = key_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A high data line at a falling edge is not a start bit; ignore it.
        if (fall && !sync_dat) begin
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {sync_dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(7)) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          parity_d = sync_dat;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (sync_dat && parity_ok(shift_q, parity_q)) begin
            if (shift_q == PS2_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
              brk_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              code_d  = shift_q;
              oext_d  = ext_q;
              orel_d  = brk_q;
              ext_d   = 1'b0;
              brk_d   = 1'b0;
              // Held key follows makes; only a matching break releases it.
              if (!brk_q) begin
                key_d = shift_q;
              end else if (shift_q == key_q) begin
                key_d = '0;
              end
            end
          end else begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Timeout only runs mid-frame; any falling edge restarts it.
    if (state_q == IDLE || fall) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1)) begin
      cnt_d   = '0;
      state_d = IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      cnt_q     <= '0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      oext_q    <= 1'b0;
      orel_q    <= 1'b0;
      key_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      oext_q    <= oext_d;
      orel_q    <= orel_d;
      key_q     <= key_d;
      err_q     <= err_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_code    = code_q;
  assign o_ext     = oext_q;
  assign o_release = orel_q;
  assign o_key     = key_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: drives PS/2 frames bit by bit and
// checks events, held key, errors, timeout, reset and latency.
module tb_ps2_key_receiver;
  import ps2_pkg::*;

  localparam int unsigned TO = 300;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_ps2_clk = 1'b1;
  logic       i_ps2_dat = 1'b1;
  logic       o_valid;
  logic [7:0] o_code;
  logic       o_ext;
  logic       o_release;
  logic [7:0] o_key;
  logic       o_err;

  int n_cmp = 0;
  int n_mis = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int v0, e0;

  ps2_key_receiver #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .o_valid   (o_valid),
    .o_code    (o_code),
    .o_ext     (o_ext),
    .o_release (o_release),
    .o_key     (o_key),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Count strobe cycles away from the active edge.
  always @(negedge i_clk) begin
    if (o_valid) valid_cnt++;
    if (o_err)   err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    i_ps2_dat = b;
    tick(4);
    i_ps2_clk = 1'b0;
    tick(8);
    i_ps2_clk = 1'b1;
    tick(4);
  endtask

  // Sends the first n bits of a frame: start, 8 data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int n);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n; i++) send_bit(f[i]);
    i_ps2_dat = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(3);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_code", 32'(o_code), 32'h0);
    check("rst_ext", 32'(o_ext), 32'h0);
    check("rst_rel", 32'(o_release), 32'h0);
    check("rst_key", 32'(o_key), 32'h0);
    check("rst_err", 32'(o_err), 32'h0);
    i_rst_n = 1'b1;
    tick(2);

    // Make 1C
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 11);
    check("make_cnt", 32'(valid_cnt - v0), 32'd1);
    check("make_code", 32'(o_code), 32'h1C);
    check("make_ext", 32'(o_ext), 32'h0);
    check("make_rel", 32'(o_release), 32'h0);
    check("make_key", 32'(o_key), 32'h1C);
    check("make_err", 32'(err_cnt - e0), 32'd0);

    // Break 1C
    v0 = valid_cnt;
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 11);
    check("brk_cnt", 32'(valid_cnt - v0), 32'd1);
    check("brk_code", 32'(o_code), 32'h1C);
    check("brk_rel", 32'(o_release), 32'h1);
    check("brk_key", 32'(o_key), 32'h00);

    // Break for a different key leaves held key alone
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1D, 1'b0, 11);
    check("other_code", 32'(o_code), 32'h1D);
    check("other_rel", 32'(o_release), 32'h1);
    check("other_key", 32'(o_key), 32'h1C);

    // Extended make and break
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    check("emake_code", 32'(o_code), 32'h75);
    check("emake_ext", 32'(o_ext), 32'h1);
    check("emake_rel", 32'(o_release), 32'h0);
    check("emake_key", 32'(o_key), 32'h75);
    v0 = valid_cnt;
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h75, 1'b0, 11);
    check("ebrk_cnt", 32'(valid_cnt - v0), 32'd1);
    check("ebrk_ext", 32'(o_ext), 32'h1);
    check("ebrk_rel", 32'(o_release), 32'h1);
    check("ebrk_key", 32'(o_key), 32'h00);

    // Parity error discards byte and pending prefix
    send_frame(8'h1C, 1'b0, 11);
    send_frame(8'hE0, 1'b0, 11);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 11);
    check("par_err", 32'(err_cnt - e0), 32'd1);
    check("par_valid", 32'(valid_cnt - v0), 32'd0);
    check("par_key", 32'(o_key), 32'h1C);
    send_frame(8'h32, 1'b0, 11);
    check("post_cnt", 32'(valid_cnt - v0), 32'd1);
    check("post_code", 32'(o_code), 32'h32);
    check("post_ext", 32'(o_ext), 32'h0);
    check("post_key", 32'(o_key), 32'h32);

    // Timeout on a stub frame
    send_frame(8'hE0, 1'b0, 11);
    e0 = err_cnt; v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 5);
    tick(TO + 20);
    check("to_err", 32'(err_cnt - e0), 32'd1);
    check("to_valid", 32'(valid_cnt - v0), 32'd0);
    check("to_idle", 32'(dut.state_q), 32'(IDLE));
    send_frame(8'h1C, 1'b0, 11);
    check("to_next_code", 32'(o_code), 32'h1C);
    check("to_next_ext", 32'(o_ext), 32'h0);
    check("to_next_key", 32'(o_key), 32'h1C);

    // Reset mid-frame
    send_frame(8'hA5, 1'b0, 5);
    i_rst_n = 1'b0;
    tick(1);
    check("mrst_code", 32'(o_code), 32'h0);
    check("mrst_key", 32'(o_key), 32'h0);
    check("mrst_valid", 32'(o_valid), 32'h0);
    check("mrst_err", 32'(o_err), 32'h0);
    check("mrst_idle", 32'(dut.state_q), 32'(IDLE));
    i_rst_n = 1'b1;
    tick(2);
    send_frame(8'h2B, 1'b0, 11);
    check("mrst_next_code", 32'(o_code), 32'h2B);
    check("mrst_next_key", 32'(o_key), 32'h2B);

    // Falling edge with data high in IDLE is ignored
    e0 = err_cnt;
    send_bit(1'b1);
    tick(TO + 20);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);
    check("glitch_idle", 32'(dut.state_q), 32'(IDLE));

    // Latency from raw stop-bit fall to o_valid
    send_frame(8'h4D, 1'b0, 10);
    i_ps2_dat = 1'b1;
    tick(4);
    i_ps2_clk = 1'b0;
    tick(1);
    check("lat_c1", 32'(o_valid), 32'h0);
    tick(1);
    check("lat_c2", 32'(o_valid), 32'h0);
    tick(1);
    check("lat_c3", 32'(o_valid), 32'h1);
    check("lat_code", 32'(o_code), 32'h4D);
    tick(1);
    check("lat_c4", 32'(o_valid), 32'h0);
    tick(5);
    i_ps2_clk = 1'b1;
    tick(4);
    check("lat_key", 32'(o_key), 32'h4D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
